// File: rtl/prime_pkg.sv
// Shared constants for the 1 Hz prime-stepping counter and its display stage.
package prime_pkg;

   localparam int DEF_WIDTH     = 8;
   localparam int DEF_MAX_VALUE = 255;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t LOAD  = 2'd1;
   localparam state_t CHECK = 2'd2;
   localparam state_t SUB   = 2'd3;

endpackage

// File: rtl/rising_edge_detect.sv
// Registers the 1 Hz wave and flags its rising edge for one clk cycle.
module rising_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic one_hz,
   output logic tick
);

   logic one_hz_q;
   logic one_hz_d;

   always_comb one_hz_d = one_hz;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) one_hz_q <= 1'b0;
      else       one_hz_q <= one_hz_d;
   end

   assign tick = one_hz & ~one_hz_q;

endmodule

// File: rtl/prime_step_checker.sv
// Counts 1 Hz ticks and trial-divides each new count by repeated subtraction.
module prime_step_checker
   import prime_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int MAX_VALUE = DEF_MAX_VALUE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             one_hz,
   output logic [WIDTH-1:0] number,
   output logic             is_prime,
   output logic             result_valid,
   output logic             busy
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);
   localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);
   localparam logic [WIDTH-1:0] FOUR  = WIDTH'(4);

   logic             tick;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] number_q, number_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             is_prime_q, is_prime_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic [2*WIDTH-1:0] d_sq;
   logic             d_sq_gt;

   rising_edge_detect u_edge (
      .clk    (clk),
      .reset  (reset),
      .one_hz (one_hz),
      .tick   (tick)
   );

   // Full-width square so the divisor bound never wraps
   assign d_sq    = {{WIDTH{1'b0}}, d_q} * {{WIDTH{1'b0}}, d_q};
   assign d_sq_gt = d_sq > {{WIDTH{1'b0}}, number_q};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         number_q   <= '0;
         d_q        <= '0;
         rem_q      <= '0;
         is_prime_q <= 1'b0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         number_q   <= number_d;
         d_q        <= d_d;
         rem_q      <= rem_d;
         is_prime_q <= is_prime_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (tick) begin
         state_d = LOAD;
      end else begin
         unique case (state_q)
            LOAD:    state_d = (number_q < FOUR) ? IDLE : CHECK;
            CHECK:   state_d = d_sq_gt ? IDLE : SUB;
            SUB: begin
               if (rem_q >= d_q)   state_d = SUB;
               else if (rem_q == '0) state_d = IDLE;
               else                state_d = CHECK;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      number_d   = number_q;
      d_d        = d_q;
      rem_d      = rem_q;
      is_prime_d = is_prime_q;
      valid_d    = valid_q;
      busy_d     = busy_q;
      if (tick) begin
         number_d = (number_q == MAX_V) ? '0 : number_q + 1'b1;
         busy_d   = 1'b1;
         valid_d  = 1'b0;
      end else begin
         unique case (state_q)
            LOAD: begin
               if (number_q < FOUR) begin
                  is_prime_d = (number_q >= TWO);
                  valid_d    = 1'b1;
                  busy_d     = 1'b0;
               end else begin
                  d_d   = TWO;
                  rem_d = number_q;
               end
            end
            CHECK: begin
               if (d_sq_gt) begin
                  is_prime_d = 1'b1;
                  valid_d    = 1'b1;
                  busy_d     = 1'b0;
               end
            end
            SUB: begin
               if (rem_q >= d_q) begin
                  rem_d = rem_q - d_q;
               end else if (rem_q == '0) begin
                  is_prime_d = 1'b0;
                  valid_d    = 1'b1;
                  busy_d     = 1'b0;
               end else begin
                  d_d   = d_q + 1'b1;
                  rem_d = number_q;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      number       = number_q;
      is_prime     = is_prime_q;
      result_valid = valid_q;
      busy         = busy_q;
   end

endmodule

// File: tb/tb_prime_step_checker.sv
// Scoreboard bench: stimulus queues expected results, monitor checks each result_valid rise.
module tb_prime_step_checker;

   logic       clk = 1'b0;
   logic       reset;
   logic       one_hz;
   logic [7:0] number;
   logic       is_prime;
   logic       result_valid;
   logic       busy;

   int cmp_cnt = 0;
   int err_cnt = 0;

   logic [8:0] exp_q[$];
   logic [8:0] mon_e;
   logic       rv_prev = 1'b0;

   int lat;
   int bcnt;

   // Hand-derived primality of 0..20
   int exp20[21] = '{0,0,1,1,0,1,0,1,0,0,0,1,0,1,0,0,0,1,0,1,0};

   always #5 clk = ~clk;

   prime_step_checker dut (
      .clk          (clk),
      .reset        (reset),
      .one_hz       (one_hz),
      .number       (number),
      .is_prime     (is_prime),
      .result_valid (result_valid),
      .busy         (busy)
   );

   task automatic check(input string name, input int act, input int req);
      cmp_cnt++;
      if (act !== req) begin
         err_cnt++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      cmp_cnt++;
      err_cnt++;
      $display("FAIL %s: got timeout/unexpected, want event", name);
   endtask

   function automatic int ref_prime(input int n);
      if (n < 2) return 0;
      for (int i = 2; i * i <= n; i++)
         if (n % i == 0) return 0;
      return 1;
   endfunction

   task automatic push_exp(input int n, input int p);
      logic [8:0] v;
      v = {n[7:0], p[0]};
      exp_q.push_back(v);
   endtask

   always @(negedge clk) begin
      if (result_valid && !rv_prev) begin
         if (exp_q.size() == 0) begin
            fail_now("unexpected_result");
         end else begin
            mon_e = exp_q.pop_front();
            check("result_number", int'(number), int'(mon_e[8:1]));
            check("result_prime", int'(is_prime), int'(mon_e[0]));
            check("busy_at_done", int'(busy), 0);
         end
      end
      rv_prev = result_valid;
   end

   task automatic wait_done(input int n, output int l, output int b);
      l = 0;
      b = 0;
      for (int k = 1; k <= 2000; k++) begin
         @(posedge clk);
         #1;
         if (result_valid) begin
            l = k;
            break;
         end
         if (busy) b++;
      end
      if (l == 0) fail_now("done_timeout");
      check("number_at_done", int'(number), n);
   endtask

   task automatic full_tick(input int n, input int p, output int l, output int b);
      @(negedge clk);
      push_exp(n, p);
      one_hz = 1'b1;
      wait_done(n, l, b);
      @(negedge clk);
      one_hz = 1'b0;
   endtask

   task automatic fast_tick(input int n);
      @(negedge clk);
      if (n < 4) push_exp(n, (n >= 2) ? 1 : 0);
      one_hz = 1'b1;
      @(negedge clk);
      one_hz = 1'b0;
   endtask

   initial begin
      int p;
      reset  = 1'b1;
      one_hz = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_number", int'(number), 0);
      check("rst_prime", int'(is_prime), 0);
      check("rst_valid", int'(result_valid), 0);
      check("rst_busy", int'(busy), 0);
      reset = 1'b0;

      for (int n = 1; n <= 20; n++) begin
         full_tick(n, exp20[n], lat, bcnt);
         if (n == 1) begin
            check("lat_n1", lat, 2);
            check("busy_cycles_n1", bcnt, 1);
         end
         if (n == 3) check("lat_n3", lat, 2);
         if (n == 4) begin
            check("lat_n4", lat, 6);
            check("busy_cycles_n4", bcnt, 5);
         end
         if (n == 9)  check("lat_n9", lat, 13);
         if (n == 15) check("lat_n15", lat, 18);
      end

      for (int n = 21; n <= 255; n++) begin
         if (n == 251)                p = 1;
         else if (n == 253 || n == 255) p = 0;
         else                         p = ref_prime(n);
         full_tick(n, p, lat, bcnt);
      end
      full_tick(0, 0, lat, bcnt);
      check("lat_wrap", lat, 2);

      for (int n = 1; n <= 250; n++) fast_tick(n);

      // Abort: 251 starts, a second edge three cycles later restarts on 252
      @(negedge clk);
      one_hz = 1'b1;
      @(negedge clk);
      one_hz = 1'b0;
      @(negedge clk);
      check("abort_busy", int'(busy), 1);
      check("abort_valid", int'(result_valid), 0);
      check("abort_number", int'(number), 251);
      push_exp(252, 0);
      @(negedge clk);
      one_hz = 1'b1;
      wait_done(252, lat, bcnt);
      @(negedge clk);
      one_hz = 1'b0;

      for (int i = 253; i <= 264; i++) fast_tick(i % 256);

      // Reset while number 9 is in its subtraction loop
      @(negedge clk);
      one_hz = 1'b1;
      repeat (5) @(negedge clk);
      check("pre_rst_busy", int'(busy), 1);
      reset = 1'b1;
      #1;
      check("mid_rst_number", int'(number), 0);
      check("mid_rst_prime", int'(is_prime), 0);
      check("mid_rst_valid", int'(result_valid), 0);
      check("mid_rst_busy", int'(busy), 0);
      @(negedge clk);
      push_exp(1, 0);
      reset = 1'b0;
      wait_done(1, lat, bcnt);
      check("lat_after_rst", lat, 2);
      @(negedge clk);
      one_hz = 1'b0;

      repeat (4) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
